// File: rtl/xor_tap_sequencer_pkg.sv
// Shared sizing, FSM state type and address packing for the XOR tap sequencer.
// Sizing comes from localparams here rather than module parameters, so the interface and all modules agree on every width.
package xor_seq_pkg;

    localparam int NUM_TAPS = 6;
    localparam int CH_W     = 5;
    localparam int DQ_W     = 16;
    localparam int DQN_W    = 11;
    localparam int ADDR_W   = CH_W + 3;
    localparam int TAP_W    = $clog2(NUM_TAPS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    // Each channel owns eight tap slots in the delay-line RAM.
    function automatic logic [ADDR_W-1:0] pack_addr(input logic [CH_W-1:0] ch,
                                                    input logic [2:0]      tap);
        return {ch, tap};
    endfunction

endpackage

// File: rtl/xor_tap_sequencer_if.sv
// Handshake, RAM and shared-XOR signals of the tap sequencer.
// Optional macro XOR_ZERO_GATE_EN adds the dq_zero flag.
interface xor_tap_sequencer_if;

    logic                             start;
    logic [xor_seq_pkg::CH_W-1:0]     chan;
    logic [xor_seq_pkg::DQ_W-1:0]     dq_in;
    logic                             busy;
    logic                             done;
    logic [xor_seq_pkg::NUM_TAPS-1:0] u_vec;
    logic                             rd_en;
    logic [xor_seq_pkg::ADDR_W-1:0]   rd_addr;
    logic [xor_seq_pkg::DQN_W-1:0]    rd_data;
    logic [xor_seq_pkg::DQ_W-1:0]     xor_dq;
    logic [xor_seq_pkg::DQN_W-1:0]    xor_dqn;
    logic                             xor_un;

`ifdef XOR_ZERO_GATE_EN
    logic                             dq_zero;

    modport master (output start, chan, dq_in, rd_data, xor_un,
                    input  busy, done, u_vec, rd_en, rd_addr, xor_dq, xor_dqn, dq_zero);
    modport slave  (input  start, chan, dq_in, rd_data, xor_un,
                    output busy, done, u_vec, rd_en, rd_addr, xor_dq, xor_dqn, dq_zero);
`else
    modport master (output start, chan, dq_in, rd_data, xor_un,
                    input  busy, done, u_vec, rd_en, rd_addr, xor_dq, xor_dqn);
    modport slave  (input  start, chan, dq_in, rd_data, xor_un,
                    output busy, done, u_vec, rd_en, rd_addr, xor_dq, xor_dqn);
`endif

endinterface

// File: rtl/xor_tap_sequencer_capture.sv
// Tap-indexed capture register: collects one Un bit per tap into the U vector.
module xor_tap_capture
    import xor_seq_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clear_i,
    input  logic                load_i,
    input  logic [TAP_W-1:0]    idx_i,
    input  logic                bit_i,
    output logic [NUM_TAPS-1:0] u_vec_o
);

    logic [NUM_TAPS-1:0] u_q, u_d;

    always_comb begin
        u_d = u_q;
        if (clear_i) begin
            u_d = '0;
        end else if (load_i) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                if (idx_i == TAP_W'(k)) begin
                    u_d[k] = bit_i;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            u_q <= '0;
        end else begin
            u_q <= u_d;
        end
    end

    assign u_vec_o = u_q;

endmodule

// File: rtl/xor_tap_sequencer.sv
// Walks the six DQn taps of one channel through the shared sign XOR and gathers U.
// Optional macro XOR_ZERO_GATE_EN skips the RAM walk when the DQ magnitude is zero.
module xor_tap_sequencer
    import xor_seq_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic scan_in0,
    input  logic scan_in1,
    input  logic scan_in2,
    input  logic scan_in3,
    input  logic scan_in4,
    input  logic scan_enable,
    input  logic test_mode,
    output logic scan_out0,
    output logic scan_out1,
    output logic scan_out2,
    output logic scan_out3,
    output logic scan_out4,
    xor_tap_sequencer_if.slave bus
);

    state_e              state_q, state_d;
    logic [TAP_W-1:0]    tap_q, tap_d;
    logic [CH_W-1:0]     chan_q, chan_d;
    logic [DQ_W-1:0]     dq_q, dq_d;
    logic                cap_q, cap_d;
    logic [TAP_W-1:0]    cap_idx_q, cap_idx_d;
    logic                clear_u;
    logic [NUM_TAPS-1:0] u_vec;
    logic                unused_scan;
`ifdef XOR_ZERO_GATE_EN
    logic                zero_q, zero_d;
`endif

    // A capture is pending in the cycle after every RAM read, tagged with the tap it belongs to.
    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        chan_d    = chan_q;
        dq_d      = dq_q;
        clear_u   = 1'b0;
        cap_d     = (state_q == RUN);
        cap_idx_d = tap_q;
`ifdef XOR_ZERO_GATE_EN
        zero_d    = zero_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    chan_d  = bus.chan;
                    dq_d    = bus.dq_in;
                    tap_d   = '0;
                    clear_u = 1'b1;
                    state_d = RUN;
`ifdef XOR_ZERO_GATE_EN
                    zero_d  = (bus.dq_in[DQ_W-2:0] == '0);
                    if (bus.dq_in[DQ_W-2:0] == '0) begin
                        state_d = DONE;
                    end
`endif
                end
            end
            RUN: begin
                tap_d = tap_q + TAP_W'(1);
                if (tap_q == TAP_W'(NUM_TAPS - 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            tap_q     <= '0;
            chan_q    <= '0;
            dq_q      <= '0;
            cap_q     <= 1'b0;
            cap_idx_q <= '0;
`ifdef XOR_ZERO_GATE_EN
            zero_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            chan_q    <= chan_d;
            dq_q      <= dq_d;
            cap_q     <= cap_d;
            cap_idx_q <= cap_idx_d;
`ifdef XOR_ZERO_GATE_EN
            zero_q    <= zero_d;
`endif
        end
    end

    xor_tap_capture u_capture (
        .clk     (clk),
        .reset   (reset),
        .clear_i (clear_u),
        .load_i  (cap_q),
        .idx_i   (cap_idx_q),
        .bit_i   (bus.xor_un),
        .u_vec_o (u_vec)
    );

    assign bus.busy    = (state_q == RUN) || (state_q == DRAIN);
    assign bus.done    = (state_q == DONE);
    assign bus.rd_en   = (state_q == RUN);
    assign bus.rd_addr = (state_q == RUN) ? pack_addr(chan_q, 3'(tap_q)) : '0;
    assign bus.xor_dq  = dq_q;
    assign bus.xor_dqn = cap_q ? bus.rd_data : '0;
    assign bus.u_vec   = u_vec;
`ifdef XOR_ZERO_GATE_EN
    assign bus.dq_zero = zero_q && (state_q == DONE);
`endif

    // Scan chain is stitched in later; until then the outputs are held low.
    assign unused_scan = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4, scan_enable, test_mode};
    assign scan_out0   = 1'b0;
    assign scan_out1   = 1'b0;
    assign scan_out2   = 1'b0;
    assign scan_out3   = 1'b0;
    assign scan_out4   = 1'b0;

endmodule

// File: tb/tb_xor_tap_sequencer.sv
// Directed self-checking bench for xor_tap_sequencer with a delay-line RAM and shared XOR model.
// Covers both builds of macro XOR_ZERO_GATE_EN.
module tb_xor_tap_sequencer;
    import xor_seq_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] scanIn;
    logic [4:0] scanOut;
    logic       scanEnable;
    logic       testMode;
    int         assertCount = 0;
    int         failCount   = 0;

    logic [DQN_W-1:0] ram [0:(1<<ADDR_W)-1];

    xor_tap_sequencer_if bus();

    xor_tap_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .scan_in0    (scanIn[0]),
        .scan_in1    (scanIn[1]),
        .scan_in2    (scanIn[2]),
        .scan_in3    (scanIn[3]),
        .scan_in4    (scanIn[4]),
        .scan_enable (scanEnable),
        .test_mode   (testMode),
        .scan_out0   (scanOut[0]),
        .scan_out1   (scanOut[1]),
        .scan_out2   (scanOut[2]),
        .scan_out3   (scanOut[3]),
        .scan_out4   (scanOut[4]),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // RAM returns data one cycle after the read strobe; the shared XOR compares sign bits.
    always @(posedge clk) begin
        bus.rd_data <= bus.rd_en ? ram[bus.rd_addr] : '0;
    end

    assign bus.xor_un = bus.xor_dq[DQ_W-1] ^ bus.xor_dqn[DQN_W-1];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic initRam();
        logic [NUM_TAPS-1:0] msbPat [0:7];
        msbPat[0] = 6'b010110;
        msbPat[1] = 6'b000111;
        msbPat[2] = 6'b101010;
        msbPat[3] = 6'b001101;
        msbPat[4] = 6'b011001;
        msbPat[5] = 6'b000000;
        msbPat[6] = 6'b000000;
        msbPat[7] = 6'b111111;
        for (int a = 0; a < (1 << ADDR_W); a++) begin
            ram[a] = '0;
        end
        for (int ch = 0; ch < 8; ch++) begin
            for (int tap = 0; tap < NUM_TAPS; tap++) begin
                ram[ADDR_W'(ch * 8 + tap)] = {msbPat[ch][tap], (DQN_W-1)'(ch * 37 + tap * 91 + 5)};
            end
        end
    endtask

    // Start is raised just after an edge so the following edge samples it as cycle 0.
    task automatic applyStimulus(input logic [CH_W-1:0] ch, input logic [DQ_W-1:0] dq);
        bus.start = 1'b1;
        bus.chan  = ch;
        bus.dq_in = dq;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic runAndCheck(input string tag, input logic [CH_W-1:0] ch, input logic [DQ_W-1:0] dq,
                               input logic [NUM_TAPS-1:0] expU, input int injectCycle,
                               input logic [CH_W-1:0] injectChan);
        logic [ADDR_W-1:0] expAddr;
        logic [DQN_W-1:0]  expDqn;
        applyStimulus(ch, dq);
        for (int cyc = 1; cyc <= NUM_TAPS + 2; cyc++) begin
            if (cyc <= NUM_TAPS) begin
                expAddr = ADDR_W'(int'(ch) * 8 + cyc - 1);
                checkOutput({tag, "_rd"}, 32'({bus.rd_en, bus.rd_addr}), 32'({1'b1, expAddr}));
            end else begin
                checkOutput({tag, "_rd_idle"}, 32'({bus.rd_en, bus.rd_addr}), 32'(0));
            end
            expDqn = (cyc >= 2 && cyc <= NUM_TAPS + 1) ? ram[ADDR_W'(int'(ch) * 8 + cyc - 2)] : '0;
            checkOutput({tag, "_xor_dqn"}, 32'(bus.xor_dqn), 32'(expDqn));
            checkOutput({tag, "_busy"}, 32'(bus.busy), 32'(cyc <= NUM_TAPS + 1));
            checkOutput({tag, "_done"}, 32'(bus.done), 32'(cyc == NUM_TAPS + 2));
            if (cyc == NUM_TAPS + 2) begin
                checkOutput({tag, "_u_vec"}, 32'(bus.u_vec), 32'(expU));
                checkOutput({tag, "_xor_dq"}, 32'(bus.xor_dq), 32'(dq));
`ifdef XOR_ZERO_GATE_EN
                checkOutput({tag, "_dq_zero"}, 32'(bus.dq_zero), 32'(0));
`endif
            end
            if (cyc == injectCycle) begin
                bus.start = 1'b1;
                bus.chan  = injectChan;
                bus.dq_in = 16'h0000;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        checkOutput({tag, "_after"}, 32'({bus.done, bus.busy, bus.rd_en}), 32'(0));
        checkOutput({tag, "_u_hold"}, 32'(bus.u_vec), 32'(expU));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy_done"}, 32'({bus.busy, bus.done}), 32'(0));
        checkOutput({tag, "_u_vec"}, 32'(bus.u_vec), 32'(0));
        checkOutput({tag, "_rd"}, 32'({bus.rd_en, bus.rd_addr}), 32'(0));
        checkOutput({tag, "_xor_dq"}, 32'(bus.xor_dq), 32'(0));
        checkOutput({tag, "_xor_dqn"}, 32'(bus.xor_dqn), 32'(0));
        checkOutput({tag, "_scan_out"}, 32'(scanOut), 32'(0));
    endtask

    initial begin
        reset      = 1'b0;
        scanIn     = 5'b10101;
        scanEnable = 1'b0;
        testMode   = 1'b0;
        bus.start  = 1'b0;
        bus.chan   = '0;
        bus.dq_in  = '0;
        initRam();

        // Reset and idle
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(posedge clk);
        #3;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("idle");

        // chan 3, negative DQ: taps 1..6 MSBs 1,0,1,1,0,0 give Un 0,1,0,0,1,1
        runAndCheck("basic", 5'd3, 16'h8005, 6'b110010, 0, 5'd0);
        runAndCheck("busy_start", 5'd3, 16'h8005, 6'b110010, 3, 5'd7);
        // chan 0, positive DQ: Un equals the tap MSBs 0,1,1,0,1,0
        runAndCheck("done_start", 5'd0, 16'h0123, 6'b010110, NUM_TAPS + 2, 5'd7);

        // Mid-operation reset on chan 5 after taps 1 and 2 were captured
        applyStimulus(5'd5, 16'h8005);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midrst_partial", 32'(bus.u_vec), 32'(6'b000011));
        checkOutput("midrst_addr", 32'(bus.rd_addr), 32'(8'd43));
        #2;
        reset = 1'b0;
        #1;
        checkAllZero("midrst");
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkAllZero("midrst_release");
        runAndCheck("post_reset", 5'd0, 16'h0123, 6'b010110, 0, 5'd0);

        // Back-to-back: chan 1 positive (Un = MSBs 1,1,1,0,0,0), chan 2 negative (Un = ~0,1,0,1,0,1)
        runAndCheck("b2b_a", 5'd1, 16'h7FFF, 6'b000111, 0, 5'd0);
        runAndCheck("b2b_b", 5'd2, 16'hC000, 6'b010101, 0, 5'd0);

        // Zero-magnitude DQ on chan 4 (MSBs 1,0,0,1,1,0)
`ifdef XOR_ZERO_GATE_EN
        applyStimulus(5'd4, 16'h8000);
        checkOutput("zero_done", 32'(bus.done), 32'(1));
        checkOutput("zero_flag", 32'(bus.dq_zero), 32'(1));
        checkOutput("zero_u_vec", 32'(bus.u_vec), 32'(0));
        checkOutput("zero_busy_rd", 32'({bus.busy, bus.rd_en}), 32'(0));
        @(posedge clk);
        #1;
        checkOutput("zero_after", 32'({bus.done, bus.dq_zero, bus.rd_en, bus.busy}), 32'(0));
`else
        runAndCheck("zero_full", 5'd4, 16'h8000, 6'b100110, 0, 5'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
